noise_thr_agc: RTL and testbench

//  Threshold calibration controller for the 2-bit (sign/magnitude) quantizer of the imitator noise source.
//  - Quantizes the signed noise samples of the mix generator into sig_o/mag_o.
//  - Adapts the magnitude threshold (Por) by successive approximation until the count of mag=1 samples
//    per measurement window matches a programmed target. Replaces the fixed compile-time Por.

---
 rtl/noise_thr_agc.sv | 176 +++++++++++++++++
 tb/tb_noise_thr_agc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/noise_thr_agc.sv
// Threshold calibration controller for the 2-bit sign/magnitude noise quantizer.
// Quantizes noise samples and tunes the magnitude threshold by successive approximation.
module noise_thr_agc #(
  parameter int NRes      = 16,
  parameter int WIN_LOG2  = 10,
  parameter int THR_INIT  = 2**(NRes-3),
  parameter int STEP_INIT = 2**(NRes-4)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic signed [NRes-1:0] smp,
  input  logic                   smp_vld,
  input  logic [WIN_LOG2:0]      tgt_cnt,
  input  logic [WIN_LOG2:0]      tol,
  output logic [NRes-2:0]        thr,
  output logic                   sig_o,
  output logic                   mag_o,
  output logic                   q_vld,
  output logic                   busy,
  output logic                   locked,
  output logic                   fail
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // MEAS  | counting valid samples and mag=1 hits over one window
  // ADJ   | one cycle: compare hits to target, adjust threshold or finish
  // DONE  | result held until next start
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MEAS = 2'd1;
  localparam logic [1:0] ST_ADJ  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int TW = NRes - 1;
  localparam int CW = WIN_LOG2 + 1;
  localparam int EW = WIN_LOG2 + 2;

  localparam logic [TW-1:0]   THR_RST  = TW'(THR_INIT);
  localparam logic [TW-1:0]   STEP_RST = TW'(STEP_INIT);
  localparam logic [TW-1:0]   THR_MAX  = {TW{1'b1}};
  localparam logic [TW-1:0]   THR_MIN  = TW'(1);
  localparam logic [CW-1:0]   WIN_LAST = CW'((2**WIN_LOG2) - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NRes-1:0] ONE_N    = NRes'(1);

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] thr_q, thr_d;
  logic [TW-1:0] step_q, step_d;
  logic [CW-1:0] smp_cnt_q, smp_cnt_d;
  logic [CW-1:0] hits_q, hits_d;
  logic          locked_q, locked_d;
  logic          fail_q, fail_d;
  logic          sig_q, sig_d;
  logic          mag_q, mag_d;
  logic          q_vld_q, q_vld_d;

  logic            smp_pos;
  logic [NRes-1:0] smp_neg_mag;
  logic            hit;
  logic signed [EW-1:0] err;
  logic [EW-1:0]   err_abs;
  logic [TW:0]     thr_sum;
  logic [TW-1:0]   thr_up;
  logic [TW-1:0]   thr_dn;

  // Zero counts as negative; the negated magnitude needs the full NRes bits for -2^(NRes-1).
  always_comb begin
    smp_pos     = ~smp[NRes-1] & (|smp);
    smp_neg_mag = ~$unsigned(smp) + ONE_N;
    if (smp_pos) hit = (smp[NRes-2:0] >= thr_q);
    else         hit = ({1'b0, thr_q} < smp_neg_mag);
  end

  always_comb begin
    sig_d   = sig_q;
    mag_d   = mag_q;
    q_vld_d = smp_vld;
    if (smp_vld) begin
      sig_d = ~smp_pos;
      mag_d = hit;
    end
  end

  always_comb begin
    err     = $signed({1'b0, hits_q}) - $signed({1'b0, tgt_cnt});
    err_abs = err[EW-1] ? $unsigned(-err) : $unsigned(err);
    thr_sum = {1'b0, thr_q} + {1'b0, step_q};
    thr_up  = thr_sum[TW] ? THR_MAX : thr_sum[TW-1:0];
    thr_dn  = (thr_q <= step_q) ? THR_MIN : (thr_q - step_q);
  end

  always_comb begin
    state_d   = state_q;
    thr_d     = thr_q;
    step_d    = step_q;
    smp_cnt_d = smp_cnt_q;
    hits_d    = hits_q;
    locked_d  = locked_q;
    fail_d    = fail_q;

    case (state_q)
      ST_IDLE: ;
      ST_MEAS: begin
        if (smp_vld) begin
          smp_cnt_d = smp_cnt_q + CNT_ONE;
          hits_d    = hits_q + {{(CW-1){1'b0}}, hit};
          if (smp_cnt_q == WIN_LAST) state_d = ST_ADJ;
        end
      end
      ST_ADJ: begin
        if (err_abs <= {1'b0, tol}) begin
          locked_d = 1'b1;
          state_d  = ST_DONE;
        end else if (step_q == '0) begin
          fail_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          // More hits than wanted means the threshold is too low.
          thr_d     = err[EW-1] ? thr_dn : thr_up;
          step_d    = step_q >> 1;
          smp_cnt_d = '0;
          hits_d    = '0;
          state_d   = ST_MEAS;
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase

    if (start) begin
      state_d   = ST_MEAS;
      thr_d     = THR_RST;
      step_d    = STEP_RST;
      smp_cnt_d = '0;
      hits_d    = '0;
      locked_d  = 1'b0;
      fail_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      thr_q     <= THR_RST;
      step_q    <= STEP_RST;
      smp_cnt_q <= '0;
      hits_q    <= '0;
      locked_q  <= 1'b0;
      fail_q    <= 1'b0;
      sig_q     <= 1'b0;
      mag_q     <= 1'b0;
      q_vld_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      thr_q     <= thr_d;
      step_q    <= step_d;
      smp_cnt_q <= smp_cnt_d;
      hits_q    <= hits_d;
      locked_q  <= locked_d;
      fail_q    <= fail_d;
      sig_q     <= sig_d;
      mag_q     <= mag_d;
      q_vld_q   <= q_vld_d;
    end
  end

  assign thr    = thr_q;
  assign sig_o  = sig_q;
  assign mag_o  = mag_q;
  assign q_vld  = q_vld_q;
  assign busy   = (state_q == ST_MEAS) || (state_q == ST_ADJ);
  assign locked = locked_q;
  assign fail   = fail_q;

endmodule

// File: tb/tb_noise_thr_agc.sv
// Directed bench for noise_thr_agc: quantizer vector table plus multi-window calibration sequences.
module tb_noise_thr_agc;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic signed [15:0] smp = '0;
  logic               smp_vld = 1'b0;
  logic [10:0]        tgt_cnt = '0;
  logic [10:0]        tol = '0;
  logic [14:0]        thr;
  logic               sig_o, mag_o, q_vld, busy, locked, fail;

  noise_thr_agc dut (
    .clk(clk), .reset_n(reset_n), .start(start), .smp(smp), .smp_vld(smp_vld),
    .tgt_cnt(tgt_cnt), .tol(tol), .thr(thr), .sig_o(sig_o), .mag_o(mag_o),
    .q_vld(q_vld), .busy(busy), .locked(locked), .fail(fail)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pat[1024];

  typedef struct {
    logic signed [15:0] s;
    logic               v;
    logic [2:0]         exp;   // {sig_o, mag_o, q_vld}
  } qv_t;
  qv_t qv[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_hits(input int t);
    int h;
    h = 0;
    foreach (pat[i]) begin
      if (pat[i] > 0) begin
        if (pat[i] >= t) h++;
      end else if (-pat[i] > t) h++;
    end
    return h;
  endfunction

  task automatic model_cal(input int tgt, input int tl, output int thr_f, output int win,
                           output int lk, output int fl);
    int t, st, h, e;
    t = 8192; st = 4096; lk = 0; fl = 0; win = 0;
    while (lk == 0 && fl == 0 && win < 40) begin
      win++;
      h = model_hits(t);
      e = h - tgt;
      if (e <= tl && e >= -tl) lk = 1;
      else if (st == 0) fl = 1;
      else begin
        if (e > 0) t = (t + st > 32767) ? 32767 : t + st;
        else       t = (t <= st) ? 1 : t - st;
        st = st >> 1;
      end
    end
    thr_f = t;
  endtask

  // Continuous valid stream from a start pulse until busy drops; returns edges after the start edge.
  task automatic run_cal(input bit use_pat, output int edges);
    int k;
    k = 0;
    start = 1'b1;
    smp_vld = 1'b1;
    smp = use_pat ? 16'(pat[0]) : 16'sd0;
    tick;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    edges = 0;
    while (edges < 20000) begin
      k++;
      smp = use_pat ? 16'(pat[k % 1024]) : 16'sd0;
      tick;
      edges++;
      if (!busy) break;
    end
  endtask

  initial begin
    int edges, got, bad, m_thr, m_win, m_lk, m_fl;
    logic [14:0] thr_hold;

    qv[0]  = '{16'sd8192,   1'b1, 3'b011};
    qv[1]  = '{16'sd8191,   1'b1, 3'b001};
    qv[2]  = '{16'sd0,      1'b1, 3'b101};
    qv[3]  = '{-16'sd8192,  1'b1, 3'b101};
    qv[4]  = '{-16'sd8193,  1'b1, 3'b111};
    qv[5]  = '{16'sd32767,  1'b0, 3'b110};
    qv[6]  = '{-16'sd32768, 1'b1, 3'b111};
    qv[7]  = '{16'sd1,      1'b1, 3'b001};
    qv[8]  = '{-16'sd1,     1'b1, 3'b101};
    qv[9]  = '{16'sd8193,   1'b1, 3'b011};
    qv[10] = '{16'sd100,    1'b0, 3'b010};
    qv[11] = '{-16'sd8191,  1'b1, 3'b101};

    // Approximately Gaussian table, sigma ~4000 (sum of four uniforms).
    foreach (pat[i])
      pat[i] = int'($urandom_range(0, 6928)) + int'($urandom_range(0, 6928)) +
               int'($urandom_range(0, 6928)) + int'($urandom_range(0, 6928)) - 13856;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({thr, sig_o, mag_o, q_vld, busy, locked, fail}), 32'({15'd8192, 6'b0}));
    reset_n = 1'b1;
    tick;

    // Quantizer table at thr = 8192
    for (int i = 0; i < 12; i++) begin
      smp = qv[i].s;
      smp_vld = qv[i].v;
      tick;
      check($sformatf("quant_vec%0d", i), 32'({sig_o, mag_o, q_vld}), 32'(qv[i].exp));
    end

    // Constant zero: thr walks down to 1, step runs out
    tgt_cnt = 11'd512;
    tol = 11'd8;
    run_cal(1'b0, edges);
    check("zero_edges", 32'(edges), 32'(14 * 1025));
    check("zero_thr", 32'(thr), 32'd1);
    check("zero_fail", 32'(fail), 32'd1);
    check("zero_locked", 32'(locked), 32'd0);
    check("zero_busy", 32'(busy), 32'd0);

    // 50% valid duty: first ADJ after 1024 valid samples = 2048 edges
    start = 1'b1;
    smp = '0;
    smp_vld = 1'b0;
    tick;
    start = 1'b0;
    check("duty_thr_init", 32'(thr), 32'd8192);
    got = -1;
    bad = 0;
    for (int n = 1; n <= 3000 && got < 0; n++) begin
      smp_vld = (n % 2 == 1);
      tick;
      if (!smp_vld && q_vld) bad++;
      if (thr != 15'd8192) got = n;
    end
    check("duty_window_edges", 32'(got), 32'd2048);
    check("duty_invalid_q_vld", 32'(bad), 32'd0);
    check("duty_thr_after_adj", 32'(thr), 32'd4096);

    // Asynchronous reset mid-MEAS
    smp_vld = 1'b1;
    smp = '0;
    repeat (3) tick;
    check("pre_rst_state", 32'({busy, sig_o, q_vld}), 32'(3'b111));
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({thr, sig_o, mag_o, q_vld, busy, locked, fail}), 32'({15'd8192, 6'b0}));
    #3 reset_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (busy || thr != 15'd8192) bad++;
    end
    check("idle_after_rst", 32'(bad), 32'd0);

    // Start coincident with the last valid sample of a window discards that window
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 1; n < 1024; n++) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart_busy_thr", 32'({busy, thr}), 32'({1'b1, 15'd8192}));
    got = -1;
    for (int n = 1; n <= 1200 && got < 0; n++) begin
      tick;
      if (thr != 15'd8192) got = n;
    end
    check("restart_next_adj", 32'(got), 32'd1025);

    // Gaussian calibration against the bench model
    tgt_cnt = 11'd325;
    tol = 11'd16;
    model_cal(325, 16, m_thr, m_win, m_lk, m_fl);
    run_cal(1'b1, edges);
    check("gauss_edges", 32'(edges), 32'(m_win * 1025));
    check("gauss_thr", 32'(thr), 32'(m_thr));
    check("gauss_locked", 32'(locked), 32'(m_lk));
    check("gauss_fail", 32'(fail), 32'(m_fl));
    check("gauss_busy", 32'(busy), 32'd0);
    check("gauss_windows_le13", 32'(edges <= 13 * 1025), 32'd1);
    check("gauss_thr_range", 32'(thr >= 15'd3400 && thr <= 15'd4600), 32'd1);

    // DONE holds results while samples keep arriving
    thr_hold = thr;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      smp = 16'(pat[n]);
      tick;
      if (thr != thr_hold || locked != 1'(m_lk) || busy) bad++;
    end
    check("done_hold", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
